// File: rtl/thermo_to_count.sv
// Multi-cycle thermometer-mask decoder: counts contiguous ones from bit 0, STEP bits per cycle,
// and flags masks with a 1 above the first 0. Define THERMO_TO_COUNT_EARLY_EXIT_EN to stop early.
module thermo_to_count #(
    parameter int  WIDTH = 8,
    parameter int  STEP  = 2,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [CW-1:0]    data_out,
    output logic             malformed,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int N   = WIDTH / STEP;
    localparam int CYW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sz_q, sz_d;
    logic             err_q, err_d;
    logic [CYW-1:0]   cyc_q, cyc_d;
    logic [CW-1:0]    data_out_q, data_out_d;
    logic             mal_q, mal_d;
    logic             out_valid_q, out_valid_d;
    logic             done;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        sz_d        = sz_q;
        err_d       = err_q;
        cyc_d       = cyc_q;
        data_out_d  = data_out_q;
        mal_d       = mal_q;
        out_valid_d = out_valid_q;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = data_in;
                    cnt_d   = '0;
                    sz_d    = 1'b0;
                    err_d   = 1'b0;
                    cyc_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Bits are consumed LSB first so the count stops at the first zero.
                for (int i = 0; i < STEP; i++) begin
                    if (shift_q[i]) begin
                        if (sz_d) err_d = 1'b1;
                        else      cnt_d = cnt_d + CW'(1);
                    end else begin
                        sz_d = 1'b1;
                    end
                end
                shift_d = shift_q >> STEP;
                cyc_d   = cyc_q + CYW'(1);
                done    = (cyc_q == CYW'(N - 1));
`ifdef THERMO_TO_COUNT_EARLY_EXIT_EN
                // Nothing left to scan can change count or error.
                if (shift_d == '0) done = 1'b1;
`else
`endif
                if (done) begin
                    state_d     = DONE;
                    data_out_d  = cnt_d;
                    mal_d       = err_d;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            sz_q        <= 1'b0;
            err_q       <= 1'b0;
            cyc_q       <= '0;
            data_out_q  <= '0;
            mal_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            sz_q        <= sz_d;
            err_q       <= err_d;
            cyc_q       <= cyc_d;
            data_out_q  <= data_out_d;
            mal_q       <= mal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign data_out  = data_out_q;
    assign malformed = mal_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_thermo_to_count.sv
// Randomized self-checking bench for thermo_to_count (WIDTH=8, STEP=2) against an arithmetic model;
// honours THERMO_TO_COUNT_EARLY_EXIT_EN for expected latency.
module tb_thermo_to_count;
    localparam int WIDTH = 8;
    localparam int STEP  = 2;
    localparam int N     = WIDTH / STEP;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data_out;
    logic       malformed;
    logic       out_valid;
    logic       out_ready;

    int passed = 0;
    int total  = 0;

    thermo_to_count #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .malformed(malformed), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference model: count = index of the first 0, malformed = any 1 at or above it.
    function automatic int model_cnt(input logic [7:0] m);
        int c = 0;
        while (c < WIDTH && m[c]) c++;
        return c;
    endfunction

    function automatic bit model_mal(input logic [7:0] m);
        int c = model_cnt(m);
        return (c < WIDTH) && ((int'(m) >> c) != 0);
    endfunction

    function automatic int model_lat(input logic [7:0] m);
`ifdef THERMO_TO_COUNT_EARLY_EXIT_EN
        int k = 1;
        while (k < N && ((int'(m) >> (k * STEP)) != 0)) k++;
        return k;
`else
        return N;
`endif
    endfunction

    // Drives one acceptance and waits for out_valid; returns edges from accept to out_valid.
    task automatic do_txn(input logic [7:0] m, input bit xfer,
                          output int lat, output logic [3:0] d, output logic mal, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        in_valid = 1'b1;
        data_in  = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        d   = data_out;
        mal = malformed;
        ok  = out_valid;
        if (xfer) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = 8'h0;
        #12;
        total++;
        if (out_valid !== 1'b0 || data_out !== 4'd0 || malformed !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_state: ov=%b do=%0d mal=%b ir=%b, want 0 0 0 0",
                     out_valid, data_out, malformed, in_ready);
        else passed++;
        @(negedge clk); rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        else passed++;
    endtask

    task automatic check_txn(input string name, input logic [7:0] m);
        int lat; logic [3:0] d; logic mal; bit ok;
        do_txn(m, 1'b1, lat, d, mal, ok);
        total++;
        if (!ok || d !== 4'(model_cnt(m)) || mal !== model_mal(m) || lat != model_lat(m))
            $display("FAIL %s mask=%h: ok=%0d cnt=%0d mal=%b lat=%0d, want cnt=%0d mal=%b lat=%0d",
                     name, m, ok, d, mal, lat, model_cnt(m), model_mal(m), model_lat(m));
        else passed++;
    endtask

    task automatic test_sweep;
        for (int k = 0; k <= WIDTH; k++) check_txn("sweep", 8'((1 << k) - 1));
    endtask

    task automatic test_malformed;
        check_txn("malformed_05", 8'h05);
        check_txn("malformed_80", 8'h80);
        check_txn("malformed_f7", 8'hF7);
        check_txn("malformed_41", 8'h41);
    endtask

    task automatic test_random;
        logic [7:0] m;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) m = 8'($urandom);
            else            m = 8'((1 << $urandom_range(0, WIDTH)) - 1) | 8'($urandom_range(0, 1) << $urandom_range(0, 7));
            check_txn("random", m);
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [3:0] d; logic mal; bit ok;
        out_ready = 1'b0;
        do_txn(8'h0F, 1'b0, lat, d, mal, ok);
        total++;
        if (!ok || d !== 4'd4) $display("FAIL bp_result: ok=%0d cnt=%0d want 4", ok, d);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || data_out !== 4'd4 || malformed !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL bp_hold: ov=%b do=%0d mal=%b ir=%b want 1 4 0 0",
                         out_valid, data_out, malformed, in_ready);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_ignored_input;
        int lat; logic [3:0] d; logic mal; bit ok;
        int extra = 0;
        @(negedge clk);
        in_valid = 1'b1; data_in = 8'h01;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; data_in = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        total++;
        if (out_valid !== 1'b1 || data_out !== 4'd1 || malformed !== 1'b0)
            $display("FAIL ignored_result: ov=%b cnt=%0d mal=%b want 1 1 0", out_valid, data_out, malformed);
        else passed++;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        total++;
        if (extra != 0) $display("FAIL ignored_single_result: extra_valid_cycles=%0d want 0", extra);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int lat; logic [3:0] d; logic mal; bit ok;
        @(negedge clk);
        in_valid = 1'b1; data_in = 8'h3F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || data_out !== 4'd0 || malformed !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_mid: ov=%b do=%0d mal=%b ir=%b want 0 0 0 0",
                     out_valid, data_out, malformed, in_ready);
        else passed++;
        @(negedge clk); rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL reset_mid_ready: in_ready=%b want 1", in_ready);
        else passed++;
        check_txn("after_reset_07", 8'h07);
    endtask

    task automatic test_back_to_back;
        int first_acc = -1, second_acc = -1, cyc = 0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; data_in = 8'h03;
        while (second_acc < 0 && cyc < 40) begin
            @(posedge clk);
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc; else second_acc = cyc;
            end
            cyc++;
        end
        @(negedge clk); in_valid = 1'b0;
        while (out_valid !== 1'b1 && cyc < 80) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        total++;
        if (second_acc < 0 || second_acc - first_acc != model_lat(8'h03) + 2)
            $display("FAIL back_to_back_interval: got=%0d want=%0d", second_acc - first_acc, model_lat(8'h03) + 2);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_sweep;
        test_malformed;
        test_random;
        test_backpressure;
        test_ignored_input;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
